// File: rtl/mdu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_exec_unit
// Brief    : Multiply/divide execution unit. Accepts one entry at a time from
//            an RS line and returns HI/LO on a valid/ready commit channel.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_exec_unit #(
    parameter int DATA_W     = 32,
    parameter int ROB_ADDR_W = 4,
    parameter int EXC_W      = 8,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ROB_ADDR_W-1:0] rob_addr_in,
    input  logic [EXC_W-1:0]      exc_type_in,
    input  logic [2:0]            op_in,
    input  logic [DATA_W-1:0]     operand_1_in,
    input  logic [DATA_W-1:0]     operand_2_in,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [ROB_ADDR_W-1:0] rob_addr_out,
    output logic [EXC_W-1:0]      exc_type_out,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic                  busy
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MUL   = 3'd4;

    localparam int c_CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]            r_op;
    logic [ROB_ADDR_W-1:0] r_rob;
    logic [EXC_W-1:0]      r_exc;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic                  r_zero_res;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_dvs;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic                  w_accept;
    logic                  w_is_div;
    logic                  w_short;
    logic                  w_op1_neg;
    logic                  w_op2_neg;
    logic [DATA_W-1:0]     w_mag1;
    logic [DATA_W-1:0]     w_mag2;
    logic [2*DATA_W-1:0]   w_prod_s;
    logic [2*DATA_W-1:0]   w_prod_u;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W:0]       w_trial;
    logic [DATA_W-1:0]     w_q_fix;
    logic [DATA_W-1:0]     w_r_fix;

    assign issue_ready = (r_state == S_IDLE) && !flush && !rst;
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = issue_valid && issue_ready;

    // Exceptions, reserved ops and divide-by-zero bypass the datapath entirely.
    assign w_is_div = (op_in == c_OP_DIV) || (op_in == c_OP_DIVU);
    assign w_short  = (exc_type_in != '0) || (op_in > c_OP_MUL) ||
                      (w_is_div && (operand_2_in == '0));

    assign w_op1_neg = (op_in == c_OP_DIV) && operand_1_in[DATA_W-1];
    assign w_op2_neg = (op_in == c_OP_DIV) && operand_2_in[DATA_W-1];
    assign w_mag1    = w_op1_neg ? -operand_1_in : operand_1_in;
    assign w_mag2    = w_op2_neg ? -operand_2_in : operand_2_in;

    assign w_prod_s = $signed({{DATA_W{r_a[DATA_W-1]}}, r_a}) *
                      $signed({{DATA_W{r_b[DATA_W-1]}}, r_b});
    assign w_prod_u = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_short) begin
                        w_state_next = S_DONE;
                    end else if (w_is_div) begin
                        w_state_next = S_DIV;
                    end else if (MUL_LAT == 1) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == c_MUL_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_valid && result_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            rob_addr_out <= '0;
            exc_type_out <= '0;
            hi_out       <= '0;
            lo_out       <= '0;
            r_op         <= '0;
            r_rob        <= '0;
            r_exc        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_zero_res   <= 1'b0;
            r_cnt        <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_dvs        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
        end else if (flush) begin
            result_valid <= 1'b0;
        end else if (w_accept) begin
            r_op       <= op_in;
            r_rob      <= rob_addr_in;
            r_exc      <= exc_type_in;
            r_a        <= operand_1_in;
            r_b        <= operand_2_in;
            r_zero_res <= w_short;
            r_cnt      <= '0;
            r_quo      <= w_mag1;
            r_rem      <= '0;
            r_dvs      <= w_mag2;
            r_neg_q    <= w_op1_neg ^ w_op2_neg;
            r_neg_r    <= w_op1_neg;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_DIV: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (!w_trial[DATA_W]) begin
                        r_rem <= w_trial[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result (and the divide sign fix).
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                        rob_addr_out <= r_rob;
                        exc_type_out <= r_exc;
                        if (r_zero_res) begin
                            hi_out <= '0;
                            lo_out <= '0;
                        end else begin
                            case (r_op)
                                c_OP_MULT: begin
                                    hi_out <= w_prod_s[2*DATA_W-1:DATA_W];
                                    lo_out <= w_prod_s[DATA_W-1:0];
                                end
                                c_OP_MULTU: begin
                                    hi_out <= w_prod_u[2*DATA_W-1:DATA_W];
                                    lo_out <= w_prod_u[DATA_W-1:0];
                                end
                                c_OP_MUL: begin
                                    hi_out <= '0;
                                    lo_out <= w_prod_s[DATA_W-1:0];
                                end
                                default: begin
                                    hi_out <= w_r_fix;
                                    lo_out <= w_q_fix;
                                end
                            endcase
                        end
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_exec_unit
// Brief    : Scoreboard bench for mdu_exec_unit: directed cases plus random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_exec_unit;

    localparam int DATA_W     = 32;
    localparam int ROB_ADDR_W = 4;
    localparam int EXC_W      = 8;
    localparam int MUL_LAT    = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [ROB_ADDR_W-1:0] rob_addr_in;
    logic [EXC_W-1:0]      exc_type_in;
    logic [2:0]            op_in;
    logic [DATA_W-1:0]     operand_1_in;
    logic [DATA_W-1:0]     operand_2_in;
    logic                  result_valid;
    logic                  result_ready;
    logic [ROB_ADDR_W-1:0] rob_addr_out;
    logic [EXC_W-1:0]      exc_type_out;
    logic [DATA_W-1:0]     hi_out;
    logic [DATA_W-1:0]     lo_out;
    logic                  busy;

    typedef struct {
        logic [3:0]  rob;
        logic [7:0]  exc;
        logic [31:0] hi;
        logic [31:0] lo;
        int          t;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;
    bit   rand_ready = 1'b0;
    logic dir_ready;
    logic rr_rand = 1'b1;

    assign result_ready = rand_ready ? rr_rand : dir_ready;

    mdu_exec_unit #(
        .DATA_W     (DATA_W),
        .ROB_ADDR_W (ROB_ADDR_W),
        .EXC_W      (EXC_W),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .rob_addr_in  (rob_addr_in),
        .exc_type_in  (exc_type_in),
        .op_in        (op_in),
        .operand_1_in (operand_1_in),
        .operand_2_in (operand_2_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .rob_addr_out (rob_addr_out),
        .exc_type_out (exc_type_out),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rr_rand = ($urandom % 4) != 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the architectural result from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] rob,
                                   input logic [7:0] exc, input int t);
        exp_t e;
        longint sa, sb_, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        e.rob = rob; e.exc = exc; e.hi = '0; e.lo = '0; e.t = t; e.lat = 1;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (exc == 0) begin
            case (op)
                3'd0: begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT; end
                3'd1: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT; end
                3'd4: begin p = sa * sb_; e.lo = p[31:0]; e.lat = MUL_LAT; end
                3'd2: if (b != 0) begin
                    q = sa / sb_; r = sa % sb_;
                    e.lo = q[31:0]; e.hi = r[31:0]; e.lat = 33;
                end
                3'd3: if (b != 0) begin
                    p = ua / ub; e.lo = p[31:0];
                    p = ua % ub; e.hi = p[31:0]; e.lat = 33;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Monitor: compares each result against the scoreboard on first sight.
    always @(negedge clk) begin
        if (!result_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got rob=%0h hi=%0h lo=%0h expected no result",
                         rob_addr_out, hi_out, lo_out);
            end else begin
                mon_e = sb.pop_front();
                check("rob", 64'(rob_addr_out), 64'(mon_e.rob));
                check("exc", 64'(exc_type_out), 64'(mon_e.exc));
                check("hi", 64'(hi_out), 64'(mon_e.hi));
                check("lo", 64'(lo_out), 64'(mon_e.lo));
                check("latency", 64'(cyc - mon_e.t), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rob, input logic [7:0] exc, input bit push,
                         output int t);
        int k = 0;
        t = -1;
        @(negedge clk);
        op_in = op; operand_1_in = a; operand_2_in = b;
        rob_addr_in = rob; exc_type_in = exc; issue_valid = 1'b1;
        while (!issue_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!issue_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got issue_ready=0 expected 1");
            issue_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        issue_valid = 1'b0;
        if (push) sb.push_back(model(op, a, b, rob, exc, t));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!result_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!result_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: got result_valid=0 expected 1");
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        logic [31:0] h0, l0;
        logic [3:0]  r0;
        logic [7:0]  e0;
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; dir_ready = 1'b1;
        op_in = '0; operand_1_in = '0; operand_2_in = '0; rob_addr_in = '0; exc_type_in = '0;
        repeat (3) @(negedge clk);
        check("rst_issue_ready", 64'(issue_ready), 64'(0));
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hilo", {hi_out, lo_out}, 64'(0));
        check("rst_tag", 64'({rob_addr_out, exc_type_out}), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_issue_ready", 64'(issue_ready), 64'(1));

        // MULT -3 * 5, then one-cycle return to IDLE
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 4'd3, 8'd0, 1'b1, t);
        wait_valid();
        check("mult_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        check("mult_idle_after", 64'({busy, result_valid, issue_ready}), 64'(3'b001));

        issue(3'd3, 32'd100, 32'd7, 4'd4, 8'd0, 1'b1, t);
        wait_valid();
        check("divu_const", {hi_out, lo_out}, {32'd2, 32'd14});
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 4'd5, 8'd0, 1'b1, t);
        wait_valid();
        check("div_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 8'd0, 1'b1, t);
        issue(3'd3, 32'd55, 32'd0, 4'd7, 8'd0, 1'b1, t);
        issue(3'd0, 32'd9, 32'd9, 4'd8, 8'h0C, 1'b1, t);
        issue(3'd6, 32'd1, 32'd2, 4'd9, 8'd0, 1'b1, t);
        issue(3'd4, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 4'd10, 8'd0, 1'b1, t);
        drain();

        // Backpressure in DONE with a competing issue_valid
        dir_ready = 1'b0;
        issue(3'd0, 32'd7, 32'd9, 4'd11, 8'd0, 1'b1, t);
        wait_valid();
        h0 = hi_out; l0 = lo_out; r0 = rob_addr_out; e0 = exc_type_out;
        op_in = 3'd1; operand_1_in = 32'd1; operand_2_in = 32'd1; rob_addr_in = 4'd12;
        issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {hi_out, lo_out}, {h0, l0});
            check("bp_tag_ready", 64'({rob_addr_out, exc_type_out, result_valid, issue_ready}),
                  64'({r0, e0, 1'b1, 1'b0}));
        end
        issue_valid = 1'b0;
        dir_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({result_valid, busy}), 64'(0));

        // Flush at T+10 of a DIV with a simultaneous issue attempt
        issue(3'd2, 32'd1000, 32'd3, 4'd13, 8'd0, 1'b0, t);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        op_in = 3'd1; operand_1_in = 32'd4; operand_2_in = 32'd4; rob_addr_in = 4'd14;
        issue_valid = 1'b1;
        #1;
        check("flush_issue_ready", 64'(issue_ready), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        check("flush_idle", 64'({busy, result_valid}), 64'(0));
        repeat (40) @(negedge clk);
        check("flush_no_result", 64'({busy, result_valid}), 64'(0));

        // Reset one cycle into a MULT
        issue(3'd0, 32'd123, 32'd456, 4'd15, 8'd0, 1'b0, t);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_hilo", {hi_out, lo_out}, 64'(0));
        check("rst_mid_state", 64'({busy, result_valid, rob_addr_out, exc_type_out}), 64'(0));
        issue(3'd1, 32'd2, 32'd3, 4'd1, 8'd0, 1'b1, t);
        wait_valid();
        check("multu_after_rst", {hi_out, lo_out}, 64'd6);
        drain();

        // Random ops under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom % 8), pick(), pick(), 4'($urandom),
                  (($urandom % 8) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, 1'b1, t);
        end
        drain();
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_exec_unit.md
Name: mdu_exec_unit

Overview:
Multiply/divide execution unit. It sits downstream of the MDU reservation-station lines as the responder on their issue/commit channel.
- Accepts one issued entry carrying ROB address, exception type, decoded MDU op and two resolved operands.
- Computes the HI/LO result: multi-cycle multiply, iterative divide.
- Returns the result on a valid/ready channel that feeds the RS line's commit inputs (commit_en, commit_exc_type, commit_data, commit_lo_data).
- Holds one operation at a time. Supports flush.

Parameters:
DATA_W, 32, operand and HI/LO width
ROB_ADDR_W, 4, ROB address width
EXC_W, 8, exception type width
MUL_LAT, 3, multiply latency in cycles from accept to result_valid (>=1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard in-flight op, return to IDLE
issue_valid  in  1  RS line presents an entry
issue_ready  out  1  unit accepts entry this cycle
rob_addr_in  in  ROB_ADDR_W  entry ROB address
exc_type_in  in  EXC_W  entry exception type (0 = none)
op_in  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MUL; 5-7 reserved
operand_1_in  in  DATA_W  rs value / dividend
operand_2_in  in  DATA_W  rt value / divisor
result_valid  out  1  result present
result_ready  in  1  commit side consumes result
rob_addr_out  out  ROB_ADDR_W  ROB address of result
exc_type_out  out  EXC_W  exception type of result
hi_out  out  DATA_W  HI result (drives commit_data)
lo_out  out  DATA_W  LO result (drives commit_lo_data)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; result_valid, busy, rob_addr_out, exc_type_out, hi_out, lo_out all 0; issue_ready = 1 (combinational, see below).
- States: IDLE, MUL, DIV, DONE.
- issue_ready = (state==IDLE) && !flush && !rst. An entry is accepted on a rising edge where issue_valid && issue_ready; that edge is T. Operands, rob_addr and exc_type are latched at T.
- Transitions at T:
  - exc_type_in != 0, or op reserved: go to DONE. exc_type passes through. hi = lo = 0. result_valid high after T+1.
  - DIV/DIVU with operand_2 == 0: go to DONE. hi = lo = 0. exc_type = 0. result_valid high after T+1.
  - MULT/MULTU/MUL: go to MUL. A counter runs MUL_LAT-1 cycles, then DONE. result_valid high after edge T+MUL_LAT.
  - DIV/DIVU: go to DIV. The datapath runs 32 restoring-divide iterations on operand magnitudes plus 1 sign-fix cycle. result_valid high after T+33.
- DONE: outputs held stable while result_ready is low. On an edge with result_valid && result_ready, go to IDLE and clear result_valid. Next accept is possible no earlier than the following edge (one bubble, by design).
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - MUL: lo = low 32 bits of the signed product; hi = 0.
  - DIVU: lo = quotient, hi = remainder.
  - DIV: quotient truncates toward zero. Quotient sign = sign1 ^ sign2; remainder sign = dividend sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- flush, any state: next state IDLE, result_valid 0, computation abandoned, no result produced. flush on the same edge as an issue handshake: flush wins, entry not accepted. flush on the same edge as a result handshake: result is dropped. The consumer ignores it because flush invalidates the RS line too.
- rst mid-operation: identical to flush, plus all output registers cleared.
- Outputs other than result_valid are don't-care when result_valid = 0. They are registered and change only on entering DONE or on reset.

Test Plan:
1. MULT 0xFFFFFFFD * 5, result_ready = 1 -> after T+3: result_valid = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, rob_addr echoed; IDLE the next cycle.
2. DIVU 100 / 7 -> result_valid first seen after T+33, lo = 14, hi = 2. DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
3. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU x / 0 -> after T+1, hi = lo = 0, exc_type = 0.
4. exc_type_in = 0x0C with MULT -> after T+1, result_valid = 1, exc_type_out = 0x0C, hi = lo = 0; no multiply cycles spent.
5. Backpressure: result_ready held low 5 cycles in DONE -> all outputs stable, issue_ready = 0, issue_valid ignored. Raise result_ready -> IDLE one edge later.
6. flush at T+10 of a DIV, issue_valid also high that cycle -> IDLE next cycle, no result_valid, entry not accepted. rst at T+1 of a MULT -> all outputs 0; a new MULTU 2*3 afterward gives hi = 0, lo = 6.
